// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry type encoding and the stored entry layout.
// Payload field widths of rob_entry_t are fixed here; the top-level width parameters default to them.
package reorder_buffer_pkg;

  localparam int unsigned EntryXlen = 32;
  localparam int unsigned EntryPrw  = 6;
  localparam int unsigned EntryPcw  = 7;

  typedef enum logic [1:0] {
    RobAlu = 2'd0,
    RobSw  = 2'd1,
    RobLw  = 2'd2
  } rob_type_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    rob_type_t            itype;
    logic [EntryPrw-1:0]  pd;
    logic [EntryPrw-1:0]  old_pd;
    logic [EntryPcw-1:0]  pc;
    logic [EntryXlen-1:0] result;
  } rob_entry_t;

  // True when the set bits form a contiguous run starting at bit 0.
  function automatic logic lanes_packed(logic [31:0] v);
    return (v & (v + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// Retire lane select: turns head-rotated valid&done bits into an in-order thermometer and a count.
module rob_retire_sel #(
  parameter int unsigned RW = 2,
  localparam int unsigned NRW = $clog2(RW + 1)
) (
  input  logic [RW-1:0]  ready,
  output logic [RW-1:0]  rt_valid,
  output logic [NRW-1:0] nret
);

  logic run;

  always_comb begin
    rt_valid = '0;
    nret     = '0;
    run      = 1'b1;
    for (int k = 0; k < RW; k++) begin
      run         = run & ready[k];
      rt_valid[k] = run;
      nret        = nret + NRW'(run);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order dispatch, tag-indexed completion, in-order multi-lane retire.
// Optional squash support is compiled in with ROB_FLUSH_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW    = 2,
  parameter int unsigned CW    = 3,
  parameter int unsigned RW    = 2,
  parameter int unsigned XLEN  = EntryXlen,
  parameter int unsigned PRW   = EntryPrw,
  parameter int unsigned PCW   = EntryPcw,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     disp_valid,
  input  logic [2*DW-1:0]   disp_type,
  input  logic [DW*PRW-1:0] disp_pd,
  input  logic [DW*PRW-1:0] disp_old_pd,
  input  logic [DW*PCW-1:0] disp_pc,
  output logic              disp_ready,
  output logic [DW*AW-1:0]  disp_tag,
  input  logic [CW-1:0]      cmp_valid,
  input  logic [CW*AW-1:0]   cmp_tag,
  input  logic [CW*XLEN-1:0] cmp_result,
  output logic [CW-1:0]      fwd_valid,
  output logic [CW*PRW-1:0]  fwd_pd,
  output logic [CW*XLEN-1:0] fwd_data,
  output logic [RW-1:0]      rt_valid,
  output logic [2*RW-1:0]    rt_type,
  output logic [RW*PRW-1:0]  rt_pd,
  output logic [RW*PRW-1:0]  rt_old_pd,
  output logic [RW*XLEN-1:0] rt_result,
  output logic [RW*PCW-1:0]  rt_pc,
  output logic [AW:0]        count,
  output logic               cmp_err
`ifdef ROB_FLUSH_EN
  ,
  input  logic               flush_valid,
  input  logic [AW-1:0]      flush_tag
`endif
);

  localparam int unsigned NRW = $clog2(RW + 1);
  localparam logic [AW:0] ReadyMax = (AW + 1)'(DEPTH - DW);

  rob_entry_t mem_q [DEPTH];
  rob_entry_t mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0]      fwd_valid_q, fwd_valid_d;
  logic [CW*PRW-1:0]  fwd_pd_q, fwd_pd_d;
  logic [CW*XLEN-1:0] fwd_data_q, fwd_data_d;
  logic err_q, err_d;

  logic [RW-1:0]  rt_ready;
  logic [NRW-1:0] nret;
  logic [AW-1:0]  rt_idx [RW];
  logic [AW:0]    ndisp;
  logic           disp_packed, disp_fire, flush;
  logic [AW-1:0]  cmp_idx [CW];
  logic [CW-1:0]  cmp_over, cmp_accept, cmp_bad;
  logic [DEPTH-1:0] squash, cmp_ignore;

`ifdef ROB_FLUSH_EN
  logic [DEPTH-1:0] sq_q, sq_d;
  logic [AW-1:0]    flush_age;

  // Entries strictly younger than flush_tag die; sq_q remembers them so late results stay quiet.
  always_comb begin
    flush      = flush_valid;
    flush_age  = flush_tag - head_q;
    squash     = '0;
    cmp_ignore = '0;
    for (int e = 0; e < DEPTH; e++) begin
      squash[e]     = flush_valid && mem_q[e].valid && ((AW'(e) - head_q) > flush_age);
      cmp_ignore[e] = squash[e] | (sq_q[e] & ~mem_q[e].valid);
    end
  end
`else
  assign flush      = 1'b0;
  assign squash     = '0;
  assign cmp_ignore = '0;
`endif

  always_comb begin
    rt_ready  = '0;
    rt_type   = '0;
    rt_pd     = '0;
    rt_old_pd = '0;
    rt_result = '0;
    rt_pc     = '0;
    for (int k = 0; k < RW; k++) begin
      rt_idx[k]   = head_q + AW'(k);
      rt_ready[k] = mem_q[rt_idx[k]].valid & mem_q[rt_idx[k]].done & ~squash[rt_idx[k]];
      rt_type[2*k +: 2]        = mem_q[rt_idx[k]].itype;
      rt_pd[k*PRW +: PRW]      = PRW'(mem_q[rt_idx[k]].pd);
      rt_old_pd[k*PRW +: PRW]  = PRW'(mem_q[rt_idx[k]].old_pd);
      rt_result[k*XLEN +: XLEN] = XLEN'(mem_q[rt_idx[k]].result);
      rt_pc[k*PCW +: PCW]      = PCW'(mem_q[rt_idx[k]].pc);
    end
  end

  rob_retire_sel #(
    .RW(RW)
  ) u_retire_sel (
    .ready   (rt_ready),
    .rt_valid(rt_valid),
    .nret    (nret)
  );

  always_comb begin
    ndisp    = '0;
    disp_tag = '0;
    for (int i = 0; i < DW; i++) begin
      ndisp = ndisp + {{AW{1'b0}}, disp_valid[i]};
      disp_tag[i*AW +: AW] = tail_q + AW'(i);
    end
    disp_packed = lanes_packed(32'(disp_valid));
    disp_ready  = count_q <= ReadyMax;
    disp_fire   = disp_ready & disp_packed & ~flush & (|disp_valid);
  end

  // Same-cycle duplicates: the highest-indexed port owns the tag.
  always_comb begin
    cmp_over   = '0;
    cmp_accept = '0;
    cmp_bad    = '0;
    for (int j = 0; j < CW; j++) begin
      cmp_idx[j] = cmp_tag[j*AW +: AW];
    end
    for (int j = 0; j < CW; j++) begin
      for (int k = j + 1; k < CW; k++) begin
        if (cmp_valid[k] && cmp_idx[k] == cmp_idx[j]) cmp_over[j] = 1'b1;
      end
      cmp_accept[j] = cmp_valid[j] & ~cmp_ignore[cmp_idx[j]] & ~cmp_over[j] &
                      mem_q[cmp_idx[j]].valid & ~mem_q[cmp_idx[j]].done;
      cmp_bad[j]    = cmp_valid[j] & ~cmp_ignore[cmp_idx[j]] &
                      (cmp_over[j] | ~mem_q[cmp_idx[j]].valid | mem_q[cmp_idx[j]].done);
    end
  end

  always_comb begin
    mem_d       = mem_q;
    fwd_valid_d = '0;
    fwd_pd_d    = '0;
    fwd_data_d  = cmp_result;
    for (int k = 0; k < RW; k++) begin
      if (rt_valid[k]) begin
        mem_d[rt_idx[k]].valid = 1'b0;
        mem_d[rt_idx[k]].done  = 1'b0;
      end
    end
    for (int j = 0; j < CW; j++) begin
      if (cmp_accept[j]) begin
        mem_d[cmp_idx[j]].done   = 1'b1;
        mem_d[cmp_idx[j]].result = EntryXlen'(cmp_result[j*XLEN +: XLEN]);
      end
      fwd_valid_d[j] = cmp_accept[j] & (mem_q[cmp_idx[j]].itype != RobLw);
      fwd_pd_d[j*PRW +: PRW] = PRW'(mem_q[cmp_idx[j]].pd);
    end
    for (int i = 0; i < DW; i++) begin
      if (disp_fire && disp_valid[i]) begin
        mem_d[tail_q + AW'(i)].valid  = 1'b1;
        mem_d[tail_q + AW'(i)].done   = 1'b0;
        mem_d[tail_q + AW'(i)].itype  = rob_type_t'(disp_type[2*i +: 2]);
        mem_d[tail_q + AW'(i)].pd     = EntryPrw'(disp_pd[i*PRW +: PRW]);
        mem_d[tail_q + AW'(i)].old_pd = EntryPrw'(disp_old_pd[i*PRW +: PRW]);
        mem_d[tail_q + AW'(i)].pc     = EntryPcw'(disp_pc[i*PCW +: PCW]);
        mem_d[tail_q + AW'(i)].result = '0;
      end
    end
    head_d  = head_q + AW'(nret);
    tail_d  = disp_fire ? tail_q + ndisp[AW-1:0] : tail_q;
    count_d = count_q + (disp_fire ? ndisp : '0) - (AW + 1)'(nret);
    err_d   = err_q | ((|disp_valid) & ~disp_packed) | (|cmp_bad);
`ifdef ROB_FLUSH_EN
    sq_d = sq_q;
    for (int i = 0; i < DW; i++) begin
      if (disp_fire && disp_valid[i]) sq_d[tail_q + AW'(i)] = 1'b0;
    end
    for (int e = 0; e < DEPTH; e++) begin
      if (squash[e]) begin
        mem_d[e].valid = 1'b0;
        mem_d[e].done  = 1'b0;
        sq_d[e]        = 1'b1;
      end
    end
    if (flush_valid) begin
      tail_d  = flush_tag + AW'(1);
      count_d = {1'b0, flush_age} + (AW + 1)'(1) - (AW + 1)'(nret);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fwd_valid_q <= '0;
      fwd_pd_q    <= '0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
`ifdef ROB_FLUSH_EN
      sq_q        <= '0;
`endif
    end else begin
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_pd_q    <= fwd_pd_d;
      fwd_data_q  <= fwd_data_d;
      err_q       <= err_d;
`ifdef ROB_FLUSH_EN
      sq_q        <= sq_d;
`endif
    end
  end

  assign fwd_valid = fwd_valid_q;
  assign fwd_pd    = fwd_pd_q;
  assign fwd_data  = fwd_data_q;
  assign count     = count_q;
  assign cmp_err   = err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=16, DW=2, CW=3, RW=2).
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  disp_valid;
  logic [3:0]  disp_type;
  logic [11:0] disp_pd, disp_old_pd;
  logic [13:0] disp_pc;
  logic        disp_ready;
  logic [7:0]  disp_tag;
  logic [2:0]  cmp_valid;
  logic [11:0] cmp_tag;
  logic [95:0] cmp_result;
  logic [2:0]  fwd_valid;
  logic [17:0] fwd_pd;
  logic [95:0] fwd_data;
  logic [1:0]  rt_valid;
  logic [3:0]  rt_type;
  logic [11:0] rt_pd, rt_old_pd;
  logic [63:0] rt_result;
  logic [13:0] rt_pc;
  logic [4:0]  count;
  logic        cmp_err;
`ifdef ROB_FLUSH_EN
  logic        flush_valid;
  logic [3:0]  flush_tag;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reorder_buffer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_valid (disp_valid),
    .disp_type  (disp_type),
    .disp_pd    (disp_pd),
    .disp_old_pd(disp_old_pd),
    .disp_pc    (disp_pc),
    .disp_ready (disp_ready),
    .disp_tag   (disp_tag),
    .cmp_valid  (cmp_valid),
    .cmp_tag    (cmp_tag),
    .cmp_result (cmp_result),
    .fwd_valid  (fwd_valid),
    .fwd_pd     (fwd_pd),
    .fwd_data   (fwd_data),
    .rt_valid   (rt_valid),
    .rt_type    (rt_type),
    .rt_pd      (rt_pd),
    .rt_old_pd  (rt_old_pd),
    .rt_result  (rt_result),
    .rt_pc      (rt_pc),
    .count      (count),
    .cmp_err    (cmp_err)
`ifdef ROB_FLUSH_EN
    ,
    .flush_valid(flush_valid),
    .flush_tag  (flush_tag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    disp_valid  = '0;
    disp_type   = '0;
    disp_pd     = '0;
    disp_old_pd = '0;
    disp_pc     = '0;
    cmp_valid   = '0;
    cmp_tag     = '0;
    cmp_result  = '0;
`ifdef ROB_FLUSH_EN
    flush_valid = 1'b0;
    flush_tag   = '0;
`endif
  endtask

  // Lane payload derived from the tag: pd = t+16, old_pd = t+40, pc = t.
  task automatic disp_lane(input int lane, input int t, input logic [1:0] ty);
    disp_valid[lane]            = 1'b1;
    disp_type[lane*2 +: 2]      = ty;
    disp_pd[lane*6 +: 6]        = 6'(t + 16);
    disp_old_pd[lane*6 +: 6]    = 6'(t + 40);
    disp_pc[lane*7 +: 7]        = 7'(t);
  endtask

  task automatic cmp_port(input int port, input int tag, input logic [31:0] val);
    cmp_valid[port]         = 1'b1;
    cmp_tag[port*4 +: 4]    = 4'(tag);
    cmp_result[port*32 +: 32] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    clear_in();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    step();
    do_reset();
    check_eq("reset_count", count, 0);
    check_eq("reset_ready", disp_ready, 1);
    check_eq("reset_rt_valid", rt_valid, 0);
    check_eq("reset_fwd_valid", fwd_valid, 0);
    check_eq("reset_err", cmp_err, 0);

    // Two ALU dispatches, out-of-order completion
    disp_lane(0, 0, 2'd0);
    disp_lane(1, 1, 2'd0);
    check_eq("disp_tag_01", disp_tag, 8'h10);
    step(); clear_in();
    check_eq("count_after_2", count, 2);
    cmp_port(0, 1, 32'h11);
    step(); clear_in();
    check_eq("no_retire_tag1_only", rt_valid, 0);
    check_eq("fwd_valid_tag1", fwd_valid, 3'b001);
    check_eq("fwd_data_tag1", fwd_data[31:0], 32'h11);
    check_eq("fwd_pd_tag1", fwd_pd[5:0], 17);
    cmp_port(0, 0, 32'h22);
    step(); clear_in();
    check_eq("rt_valid_both", rt_valid, 2'b11);
    check_eq("rt_pd_lane0", rt_pd[5:0], 16);
    check_eq("rt_old_pd_lane1", rt_old_pd[11:6], 41);
    check_eq("rt_result_lane1", rt_result[63:32], 32'h11);
    check_eq("rt_result_lane0", rt_result[31:0], 32'h22);
    step();
    check_eq("count_after_retire", count, 0);
    check_eq("rt_valid_empty", rt_valid, 0);

    // Fill from head 0; tag 3 is a load
    do_reset();
    for (int c = 0; c < 8; c++) begin
      disp_lane(0, 2 * c, 2'd0);
      disp_lane(1, 2 * c + 1, (2 * c + 1 == 3) ? 2'd2 : 2'd0);
      step(); clear_in();
    end
    check_eq("full_count", count, 16);
    check_eq("full_ready", disp_ready, 0);
    disp_lane(0, 0, 2'd0);
    disp_lane(1, 1, 2'd0);
    step(); clear_in();
    check_eq("full_disp_dropped", count, 16);
    check_eq("full_disp_no_err", cmp_err, 0);
    cmp_port(0, 0, 32'h100);
    cmp_port(1, 1, 32'h101);
    step(); clear_in();
    check_eq("full_rt_valid", rt_valid, 2'b11);
    check_eq("full_ready_pre_retire", disp_ready, 0);
    step();
    check_eq("count_after_full_retire", count, 14);
    check_eq("ready_after_retire", disp_ready, 1);
    disp_lane(0, 0, 2'd0);
    disp_lane(1, 1, 2'd0);
    check_eq("wrap_disp_tag", disp_tag, 8'h10);
    step(); clear_in();
    check_eq("refull_count", count, 16);

    // LW completion is not forwarded; ALU completion is
    cmp_port(0, 3, 32'h40);
    cmp_port(1, 4, 32'h7);
    step(); clear_in();
    check_eq("fwd_valid_lw_alu", fwd_valid, 3'b010);
    check_eq("fwd_data_alu", fwd_data[63:32], 32'h7);
    check_eq("fwd_pd_alu", fwd_pd[11:6], 20);

    // Ports 0 and 2 to tag 5: port 2 wins and the collision is flagged
    cmp_port(0, 5, 32'hA);
    cmp_port(2, 5, 32'hB);
    step(); clear_in();
    check_eq("dup_fwd_valid", fwd_valid, 3'b100);
    check_eq("dup_fwd_data", fwd_data[95:64], 32'hB);
    check_eq("dup_err", cmp_err, 1);
    cmp_port(0, 2, 32'h55);
    step(); clear_in();
    check_eq("rt_valid_23", rt_valid, 2'b11);
    check_eq("rt_type_lw", rt_type[3:2], 2'd2);
    check_eq("rt_result_lw", rt_result[63:32], 32'h40);
    step();
    check_eq("count_after_23", count, 14);
    check_eq("rt_valid_45", rt_valid, 2'b11);
    check_eq("rt_result_tag4", rt_result[31:0], 32'h7);
    check_eq("rt_result_tag5", rt_result[63:32], 32'hB);

    // Reset with a live completion pending
    cmp_port(0, 6, 32'h66);
    do_reset();
    check_eq("midreset_count", count, 0);
    check_eq("midreset_rt_valid", rt_valid, 0);
    check_eq("midreset_fwd_valid", fwd_valid, 0);
    check_eq("midreset_err", cmp_err, 0);
    check_eq("midreset_ready", disp_ready, 1);

    // Completion to an invalid entry
    cmp_port(0, 9, 32'h9);
    step(); clear_in();
    check_eq("bad_tag_err", cmp_err, 1);
    check_eq("bad_tag_no_fwd", fwd_valid, 0);
    step();
    step();
    check_eq("err_sticky", cmp_err, 1);

    // Non-packed dispatch lanes
    do_reset();
    disp_valid = 2'b10;
    step(); clear_in();
    check_eq("gap_count", count, 0);
    check_eq("gap_err", cmp_err, 1);

`ifdef ROB_FLUSH_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      disp_lane(0, 2 * c, 2'd0);
      disp_lane(1, 2 * c + 1, 2'd0);
      step(); clear_in();
    end
    flush_valid = 1'b1;
    flush_tag   = 4'd3;
    step(); clear_in();
    check_eq("flush_count", count, 4);
    check_eq("flush_next_tag", disp_tag[3:0], 4);
    cmp_port(0, 6, 32'h6);
    step(); clear_in();
    check_eq("flush_late_cmp_err", cmp_err, 0);
    check_eq("flush_late_cmp_fwd", fwd_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
